rst_stall_ctrl: RTL and testbench
=================================

RST_STALL_CTRL -- requirements
Module: rst_stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 5: power-on hold counter width; hold lasts 2^CNT_W cycles.
REQ-002 SHALL have parameter N_DOM, default 2: number of staged reset domains (1..8).
REQ-003 SHALL have parameter STAGE_GAP, default 4: cycles between successive domain releases (>=1).
REQ-004 SHALL have parameter N_STALL, default 2: number of stall requesters (1..8).
REQ-005 SHALL have parameter TO_W, default 6: stall watchdog counter width.
REQ-006 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port reset_n_i, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port soft_rst_i, input, 1: synchronous request to re-run the reset sequence.
REQ-009 SHALL have port stall_req_i, input, N_STALL: per-requester clock-stall request, level.
REQ-010 SHALL have port dom_rst_n_o, output, N_DOM: per-domain active-low reset.
REQ-011 SHALL have port clk_en_o, output, 1: registered processor clock enable.
REQ-012 SHALL have port stall_ack_o, output, N_STALL: per-requester stall granted.
REQ-013 SHALL have ports ready_o (1: sequence done) and stall_timeout_o (1: sticky watchdog flag), outputs.
REQ-014 SHALL have port state_o, output, 2: current FSM state encoding.

Function
REQ-015 SHALL implement FSM states HOLD=0, RELEASE=1, RUN=2; encoding 3 unused, decodes to HOLD.
REQ-016 HOLD: counter counts 0..2^CNT_W-1; at terminal count SHALL enter RELEASE next cycle.
REQ-017 RELEASE: on relative cycle k*STAGE_GAP (k=0..N_DOM-1) SHALL set dom_rst_n_o[k]=1, ascending order; cycle after last release SHALL enter RUN.
REQ-018 RUN: ready_o SHALL be 1; it SHALL be 0 in HOLD and RELEASE.
REQ-019 clk_en_o SHALL be 1 in HOLD and RELEASE; in RUN it SHALL be registered ~|stall_req_i (one-cycle latency).
REQ-020 stall_ack_o SHALL be registered stall_req_i & (state==RUN) & ~stall_timeout_o.
REQ-021 Watchdog counter SHALL increment each RUN cycle with any stall_req_i high, clear to 0 when none high, saturate at 2^TO_W-1.
REQ-022 On reaching 2^TO_W-1, stall_timeout_o SHALL set next cycle and stay set; while set, clk_en_o SHALL be 1 and stall_ack_o all 0.
REQ-023 soft_rst_i high in any state SHALL, next cycle: all dom_rst_n_o=0, state HOLD, hold counter 0, stall_timeout_o=0, watchdog 0.
REQ-024 soft_rst_i held high SHALL keep FSM in HOLD with counter at 0.
REQ-025 Stall requests in HOLD/RELEASE SHALL be ignored (no ack, no watchdog count).

Reset
REQ-026 reset_n_i low SHALL immediately force: dom_rst_n_o=0, clk_en_o=0, stall_ack_o=0, ready_o=0, stall_timeout_o=0, state_o=HOLD, all counters 0.
REQ-027 reset_n_i deassertion SHALL pass a 2-flop synchroniser; HOLD counting SHALL start the cycle after the synchronised release.
REQ-028 Reset assertion mid-RELEASE or mid-stall SHALL abort asynchronously with REQ-026 values.

Structure
REQ-029 State encodings and default parameter values SHALL live in the shared defines include, beside the rv32i defines.
REQ-030 Reset synchroniser SHALL be a separate sub-module reset_sync (async assert, 2-flop sync deassert).

Verification
REQ-031 Defaults, release reset_n_i at t0 -> 2 sync cycles, 32 HOLD cycles, dom_rst_n_o=01 then 11 four cycles later, ready_o=1 next cycle.
REQ-032 RUN, stall_req_i=01 for 3 cycles -> clk_en_o=0 and stall_ack_o=01 for 3 cycles, each delayed 1 cycle; no timeout.
REQ-033 RUN, stall_req_i=10 held 70 cycles -> stall_timeout_o=1 after 64 counted cycles; clk_en_o returns to 1, ack 00.
REQ-034 soft_rst_i pulse during RELEASE after dom 0 released -> dom_rst_n_o=00 next cycle, full 32-cycle HOLD, sequence repeats.
REQ-035 reset_n_i low mid-stall in RUN -> all outputs to REQ-026 values without a clock edge.
REQ-036 N_DOM=4, STAGE_GAP=1, CNT_W=2 -> 4 HOLD cycles, domains release on consecutive cycles 0,1,2,3, RUN on cycle 4.

Source files
------------

// File: rtl/rst_stall_ctrl_pkg.sv
// Shared types and default parameters for the reset/stall controller.
package rst_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int DEF_CNT_W     = 5;
  localparam int DEF_N_DOM     = 2;
  localparam int DEF_STAGE_GAP = 4;
  localparam int DEF_N_STALL   = 2;
  localparam int DEF_TO_W      = 6;

  // Relative RELEASE cycle on which the last domain comes out of reset.
  function automatic int rel_last(input int n_dom, input int gap);
    return (n_dom - 1) * gap;
  endfunction

endpackage

// File: rtl/rst_stall_ctrl_reset_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after two clock edges.
module rst_stall_ctrl_reset_sync (
  input  logic clk,
  input  logic arst_n,
  output logic rst_sync_n
);

  logic meta_q;
  logic sync_q;

  // Two-flop chain; both flops clear immediately on arst_n low.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign rst_sync_n = sync_q;

endmodule

// File: rtl/rst_stall_ctrl.sv
// Power-on reset sequencer with staged domain release and a clock-stall
// arbiter guarded by a sticky watchdog.
//
// state   | meaning
// --------+-------------------------------------------------------------
// HOLD    | all domains in reset, hold counter runs to terminal count
// RELEASE | domains leave reset one by one, STAGE_GAP cycles apart
// RUN     | sequence done; stall requests gate the processor clock
module rst_stall_ctrl
  import rst_stall_ctrl_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int N_DOM     = DEF_N_DOM,
  parameter int STAGE_GAP = DEF_STAGE_GAP,
  parameter int N_STALL   = DEF_N_STALL,
  parameter int TO_W      = DEF_TO_W
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               soft_rst_i,
  input  logic [N_STALL-1:0] stall_req_i,
  output logic [N_DOM-1:0]   dom_rst_n_o,
  output logic               clk_en_o,
  output logic [N_STALL-1:0] stall_ack_o,
  output logic               ready_o,
  output logic               stall_timeout_o,
  output logic [1:0]         state_o
);

  localparam int REL_LAST = rel_last(N_DOM, STAGE_GAP);
  localparam int REL_W    = $clog2(REL_LAST + 2);

  localparam logic [CNT_W-1:0] HOLD_TC = '1;
  localparam logic [TO_W-1:0]  WD_MAX  = '1;
  localparam logic [REL_W-1:0] REL_TC  = REL_W'(REL_LAST);

  logic               rst_sync_n;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [REL_W-1:0]   rel_cnt_q, rel_cnt_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic               to_q, to_d;
  logic [N_DOM-1:0]   dom_q, dom_d;
  logic               clk_en_q, clk_en_d;
  logic [N_STALL-1:0] ack_q, ack_d;
  logic               any_stall;
  logic               in_run;

  rst_stall_ctrl_reset_sync u_reset_sync (
    .clk        (clk_i),
    .arst_n     (reset_n_i),
    .rst_sync_n (rst_sync_n)
  );

  assign any_stall = |stall_req_i;
  assign in_run    = (state_q == ST_RUN);

  // Sequencer: hold count, staged release, then park in RUN until soft reset.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    if (soft_rst_i) begin
      state_d    = ST_HOLD;
      hold_cnt_d = '0;
      rel_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_RELEASE: begin
          if (rel_cnt_q == REL_TC) begin
            state_d   = ST_RUN;
            rel_cnt_d = '0;
          end else begin
            rel_cnt_d = rel_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          // The unused encoding behaves exactly like HOLD.
          state_d = ST_HOLD;
          if (hold_cnt_q == HOLD_TC) begin
            state_d    = ST_RELEASE;
            hold_cnt_d = '0;
            rel_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Watchdog, stall grant and clock enable; a fresh timeout suppresses grants
  // on the same edge it sets, so ack never overlaps the flag.
  always_comb begin
    wd_d     = '0;
    to_d     = 1'b0;
    ack_d    = '0;
    clk_en_d = 1'b1;
    if (!soft_rst_i) begin
      to_d = to_q | (wd_q == WD_MAX);
      if (in_run && any_stall) begin
        wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
      end
      if (in_run && !to_d) begin
        ack_d    = stall_req_i;
        clk_en_d = ~any_stall;
      end
    end
  end

  // Domain resets follow the upcoming state and release offset.
  always_comb begin
    dom_d = '0;
    case (state_d)
      ST_RUN: dom_d = '1;
      ST_RELEASE: begin
        for (int k = 0; k < N_DOM; k++) begin
          dom_d[k] = (rel_cnt_d >= REL_W'(k * STAGE_GAP));
        end
      end
      default: dom_d = '0;
    endcase
  end

  // State and output registers, cleared asynchronously by the synchronised reset.
  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      rel_cnt_q  <= '0;
      wd_q       <= '0;
      to_q       <= 1'b0;
      dom_q      <= '0;
      clk_en_q   <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      wd_q       <= wd_d;
      to_q       <= to_d;
      dom_q      <= dom_d;
      clk_en_q   <= clk_en_d;
      ack_q      <= ack_d;
    end
  end

  assign dom_rst_n_o     = dom_q;
  assign clk_en_o        = clk_en_q;
  assign stall_ack_o     = ack_q;
  assign ready_o         = (state_q == ST_RUN);
  assign stall_timeout_o = to_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_rst_stall_ctrl.sv
// Bench for rst_stall_ctrl: two configurations share one stimulus stream and
// are compared each cycle against a timeline-based reference model.
module tb_rst_stall_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b1;
  logic       soft_rst_i = 1'b0;
  logic [1:0] stall_req_i = 2'b00;

  logic [1:0] a_dom;
  logic       a_clk_en;
  logic [1:0] a_ack;
  logic       a_ready;
  logic       a_to;
  logic [1:0] a_state;

  logic [3:0] b_dom;
  logic       b_clk_en;
  logic [1:0] b_ack;
  logic       b_ready;
  logic       b_to;
  logic [1:0] b_state;

  int n_assert = 0;
  int n_fail   = 0;

  // Per-instance configuration as the model sees it.
  int p_hold_len[2];
  int p_rel_len[2];
  int p_gap[2];
  int p_ndom[2];
  int p_wd_lim[2];

  // Model: m_t is cycles since the sequence (re)started.
  int         m_t[2];
  int         m_sync[2];
  int         m_streak[2];
  bit         m_to[2];
  bit         m_clk_en[2];
  logic [1:0] m_ack[2];

  always #5 clk_i = ~clk_i;

  rst_stall_ctrl u_dut_a (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .soft_rst_i      (soft_rst_i),
    .stall_req_i     (stall_req_i),
    .dom_rst_n_o     (a_dom),
    .clk_en_o        (a_clk_en),
    .stall_ack_o     (a_ack),
    .ready_o         (a_ready),
    .stall_timeout_o (a_to),
    .state_o         (a_state)
  );

  rst_stall_ctrl #(
    .CNT_W(2), .N_DOM(4), .STAGE_GAP(1), .N_STALL(2), .TO_W(4)
  ) u_dut_b (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .soft_rst_i      (soft_rst_i),
    .stall_req_i     (stall_req_i),
    .dom_rst_n_o     (b_dom),
    .clk_en_o        (b_clk_en),
    .stall_ack_o     (b_ack),
    .ready_o         (b_ready),
    .stall_timeout_o (b_to),
    .state_o         (b_state)
  );

  function automatic logic [1:0] exp_state(input int i);
    if (m_t[i] < p_hold_len[i]) return 2'd0;
    if (m_t[i] < p_hold_len[i] + p_rel_len[i]) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [7:0] exp_dom(input int i);
    logic [7:0] d;
    d = '0;
    for (int k = 0; k < p_ndom[i]; k++) begin
      if (m_t[i] >= p_hold_len[i] + k * p_gap[i]) d[k] = 1'b1;
    end
    return d;
  endfunction

  task automatic model_reset_one(input int i);
    m_t[i]      = 0;
    m_sync[i]   = 0;
    m_streak[i] = 0;
    m_to[i]     = 1'b0;
    m_clk_en[i] = 1'b0;
    m_ack[i]    = 2'b00;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) model_reset_one(i);
  endtask

  task automatic model_edge();
    logic [1:0] st_b;
    bit         to_new;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n_i) begin
        model_reset_one(i);
      end else begin
        if (m_sync[i] >= 2) begin
          st_b = exp_state(i);
          if (soft_rst_i) begin
            m_t[i]      = 0;
            m_to[i]     = 1'b0;
            m_streak[i] = 0;
            m_clk_en[i] = 1'b1;
            m_ack[i]    = 2'b00;
          end else begin
            to_new = m_to[i] || (m_streak[i] >= p_wd_lim[i]);
            if (st_b == 2'd2 && stall_req_i != 2'b00) m_streak[i]++;
            else m_streak[i] = 0;
            m_ack[i]    = (st_b == 2'd2 && !to_new) ? stall_req_i : 2'b00;
            m_clk_en[i] = (st_b != 2'd2) || to_new || (stall_req_i == 2'b00);
            m_to[i]     = to_new;
            if (m_t[i] < 100000) m_t[i]++;
          end
        end
        if (m_sync[i] < 2) m_sync[i]++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_dom",    8'(a_dom),    exp_dom(0));
    check("a_clk_en", 8'(a_clk_en), 8'(m_clk_en[0]));
    check("a_ack",    8'(a_ack),    8'(m_ack[0]));
    check("a_ready",  8'(a_ready),  8'(exp_state(0) == 2'd2));
    check("a_to",     8'(a_to),     8'(m_to[0]));
    check("a_state",  8'(a_state),  8'(exp_state(0)));
    check("b_dom",    8'(b_dom),    exp_dom(1));
    check("b_clk_en", 8'(b_clk_en), 8'(m_clk_en[1]));
    check("b_ack",    8'(b_ack),    8'(m_ack[1]));
    check("b_ready",  8'(b_ready),  8'(exp_state(1) == 2'd2));
    check("b_to",     8'(b_to),     8'(m_to[1]));
    check("b_state",  8'(b_state),  8'(exp_state(1)));
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check_all();
  endtask

  initial begin
    p_hold_len[0] = 32; p_rel_len[0] = 5; p_gap[0] = 4; p_ndom[0] = 2; p_wd_lim[0] = 63;
    p_hold_len[1] = 4;  p_rel_len[1] = 4; p_gap[1] = 1; p_ndom[1] = 4; p_wd_lim[1] = 15;
    model_reset();

    #1 reset_n_i = 1'b0;
    @(negedge clk_i);
    check_all();
    repeat (3) tick();

    // Power-on sequence through to RUN.
    reset_n_i = 1'b1;
    repeat (45) tick();

    // Short stall from requester 0.
    stall_req_i = 2'b01;
    repeat (3) tick();
    stall_req_i = 2'b00;
    repeat (4) tick();

    // Long stall from requester 1 runs into the watchdog.
    stall_req_i = 2'b10;
    repeat (70) tick();
    stall_req_i = 2'b00;
    repeat (4) tick();

    // Restart, then soft reset while instance A is mid-RELEASE.
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    for (int n = 0; n < 200 && m_t[0] != p_hold_len[0] + 1; n++) tick();
    check("a_mid_release_dom", 8'(a_dom), 8'h01);
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    repeat (45) tick();

    // Soft reset held with stalls asserted.
    stall_req_i = 2'b11;
    soft_rst_i  = 1'b1;
    repeat (6) tick();
    soft_rst_i  = 1'b0;
    stall_req_i = 2'b00;
    repeat (40) tick();

    // Randomised stall segments with occasional soft resets.
    for (int seg = 0; seg < 40; seg++) begin
      stall_req_i = 2'($urandom_range(0, 3));
      soft_rst_i  = ($urandom_range(0, 19) == 0);
      repeat ($urandom_range(1, 25)) begin
        tick();
        soft_rst_i = 1'b0;
      end
    end

    // Hard reset in the middle of a stall, checked without a clock edge.
    soft_rst_i  = 1'b0;
    stall_req_i = 2'b00;
    repeat (45) tick();
    stall_req_i = 2'b11;
    repeat (3) tick();
    #2 reset_n_i = 1'b0;
    model_reset();
    #1 check_all();
    repeat (2) tick();
    reset_n_i   = 1'b1;
    stall_req_i = 2'b00;
    repeat (50) tick();

    for (int n = 0; n < 100; n++) begin
      stall_req_i = 2'($urandom_range(0, 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
